// File: rtl/frame_readout_sequencer.sv
// Reads one frame from the frame RAM and streams it to the UART Tx using a start/busy handshake.
// Optional FRAME_HEADER_EN prepends the sync bytes 0xAA, 0x55 before pixel 0.
module frame_readout_sequencer #(
  parameter int BYTES_PER_FRAME = 9216,
  parameter int ADDR_W          = 15,
  parameter int GAP_CYCLES      = 62500000,
  parameter int GAP_W           = 26
) (
  input  logic              Clk,
  input  logic              i_Rst_n,
  input  logic              i_VS,
  input  logic              i_Tx_Busy,
  input  logic [7:0]        i_Rd_Data,
  output logic [ADDR_W-1:0] o_Rd_Addr,
  output logic [7:0]        o_Tx_Byte,
  output logic              o_Tx_Start,
  output logic              o_Write_Lock,
  output logic              o_Frame_Indicator,
  output logic              o_Busy
);

  typedef enum logic [2:0] {IDLE, PRE_GAP, FETCH, LOAD, WAIT_TX, POST_GAP} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_FRAME - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_start_q, tx_start_d;
  logic              lock_q, lock_d;
  logic              frame_ind_q, frame_ind_d;
  logic              busy_q, busy_d;
  logic [GAP_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic              vs_meta_q, vs_sync_q, vs_prev_q, vs_rise_q;
`ifdef FRAME_HEADER_EN
  logic              hdr_q, hdr_d;
  logic [1:0]        hdr_idx_q, hdr_idx_d;
`endif

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    tx_byte_d  = tx_byte_q;
    tx_start_d = 1'b0;
    lock_d     = lock_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
`ifdef FRAME_HEADER_EN
    hdr_d      = hdr_q;
    hdr_idx_d  = hdr_idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (vs_rise_q) begin
          state_d = PRE_GAP;
          cnt_d   = '0;
          lock_d  = 1'b1;
        end
      end
      PRE_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d     = '0;
          rd_addr_d = '0;
`ifdef FRAME_HEADER_EN
          hdr_d     = 1'b1;
          hdr_idx_d = 2'd0;
          state_d   = LOAD;
`else
          state_d   = FETCH;
`endif
        end else begin
          cnt_d = cnt_q + GAP_W'(1);
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
`ifdef FRAME_HEADER_EN
        if (hdr_q) tx_byte_d = (hdr_idx_q == 2'd0) ? 8'hAA : 8'h55;
        else       tx_byte_d = i_Rd_Data;
`else
        tx_byte_d  = i_Rd_Data;
`endif
        tx_start_d = 1'b1;
        first_d    = 1'b1;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        // Tx raises busy one cycle after the start pulse, so skip the first look.
        if (first_q) begin
          first_d = 1'b0;
        end else if (!i_Tx_Busy) begin
`ifdef FRAME_HEADER_EN
          if (hdr_q) begin
            if (hdr_idx_q == 2'd1) begin
              hdr_d   = 1'b0;
              state_d = FETCH;
            end else begin
              hdr_idx_d = hdr_idx_q + 2'd1;
              state_d   = LOAD;
            end
          end else
`endif
          if (rd_addr_q == LAST_ADDR) begin
            rd_addr_d = '0;
            lock_d    = 1'b0;
            cnt_d     = '0;
            state_d   = POST_GAP;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
            state_d   = FETCH;
          end
        end
      end
      POST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    frame_ind_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      tx_byte_q   <= '0;
      tx_start_q  <= 1'b0;
      lock_q      <= 1'b0;
      frame_ind_q <= 1'b1;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      vs_meta_q   <= 1'b0;
      vs_sync_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      vs_rise_q   <= 1'b0;
`ifdef FRAME_HEADER_EN
      hdr_q       <= 1'b0;
      hdr_idx_q   <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      tx_byte_q   <= tx_byte_d;
      tx_start_q  <= tx_start_d;
      lock_q      <= lock_d;
      frame_ind_q <= frame_ind_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      vs_meta_q   <= i_VS;
      vs_sync_q   <= vs_meta_q;
      vs_prev_q   <= vs_sync_q;
      vs_rise_q   <= vs_sync_q & ~vs_prev_q;
`ifdef FRAME_HEADER_EN
      hdr_q       <= hdr_d;
      hdr_idx_q   <= hdr_idx_d;
`endif
    end
  end

  assign o_Rd_Addr         = rd_addr_q;
  assign o_Tx_Byte         = tx_byte_q;
  assign o_Tx_Start        = tx_start_q;
  assign o_Write_Lock      = lock_q;
  assign o_Frame_Indicator = frame_ind_q;
  assign o_Busy            = busy_q;

endmodule

// File: tb/tb_frame_readout_sequencer.sv
// Scoreboard bench for frame_readout_sequencer: small frame, short gaps, RAM data = addr+0x10.
module tb_frame_readout_sequencer;
  localparam int BPF  = 4;
  localparam int GAP  = 16;
  localparam int AW   = 15;
`ifdef FRAME_HEADER_EN
  localparam int HDR  = 2;
`else
  localparam int HDR  = 0;
`endif
  localparam int NSTART = BPF + HDR;

  logic          Clk = 1'b0;
  logic          i_Rst_n = 1'b0;
  logic          i_VS = 1'b0;
  logic          i_Tx_Busy;
  logic [7:0]    i_Rd_Data = 8'h00;
  logic [AW-1:0] o_Rd_Addr;
  logic [7:0]    o_Tx_Byte;
  logic          o_Tx_Start, o_Write_Lock, o_Frame_Indicator, o_Busy;

  frame_readout_sequencer #(.BYTES_PER_FRAME(BPF), .ADDR_W(AW), .GAP_CYCLES(GAP), .GAP_W(26)) dut (
    .Clk(Clk), .i_Rst_n(i_Rst_n), .i_VS(i_VS), .i_Tx_Busy(i_Tx_Busy), .i_Rd_Data(i_Rd_Data),
    .o_Rd_Addr(o_Rd_Addr), .o_Tx_Byte(o_Tx_Byte), .o_Tx_Start(o_Tx_Start),
    .o_Write_Lock(o_Write_Lock), .o_Frame_Indicator(o_Frame_Indicator), .o_Busy(o_Busy));

  always #5 Clk = ~Clk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int frame_starts = 0;
  int idle_rises = 0;
  bit long_mode = 0;
  bit prev_start = 0, prev_ind = 1;
  int busy_cnt;
  logic [7:0] exp_q[$];

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // RAM: registered read, one cycle latency
  always @(posedge Clk) i_Rd_Data <= 8'h10 + 8'(o_Rd_Addr);

  // Tx: busy for 20 cycles starting the cycle after the start pulse
  always @(posedge Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) busy_cnt <= 0;
    else if (o_Tx_Start) busy_cnt <= (long_mode && frame_starts == HDR + 2) ? 200 : 20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign i_Tx_Busy = (busy_cnt != 0);

  // Monitor
  always @(negedge Clk) begin
    if (i_Rst_n && o_Tx_Start) begin
      frame_starts++;
      if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
      else chk("tx_byte", int'(o_Tx_Byte), int'(exp_q.pop_front()));
    end
    if (i_Rst_n && o_Tx_Start && prev_start) chk("back_to_back_start", 1, 0);
    if (o_Frame_Indicator && !prev_ind) idle_rises++;
    prev_start = o_Tx_Start;
    prev_ind   = o_Frame_Indicator;
  end

  task automatic push_frame();
`ifdef FRAME_HEADER_EN
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
`endif
    for (int i = 0; i < BPF; i++) exp_q.push_back(8'(8'h10 + i));
  endtask

  task automatic launch();
    int c0;
    bit seen;
    @(negedge Clk);
    c0 = cyc; i_VS = 1'b1; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (o_Write_Lock) seen = 1;
    end
    chk("lock_rise_seen", int'(seen), 1);
    if (seen) chk("lock_latency", cyc - c0, 4);
    i_VS = 1'b0;
  endtask

  task automatic wait_starts(int n, int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge Clk);
      if (frame_starts >= n) ok = 1;
    end
    if (!ok) chk("wait_starts_timeout", frame_starts, n);
  endtask

  task automatic wait_idle(int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge Clk);
      if (o_Frame_Indicator) ok = 1;
    end
    if (!ok) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_rd_addr"}, int'(o_Rd_Addr), 0);
    chk({tag, "_tx_byte"}, int'(o_Tx_Byte), 0);
    chk({tag, "_tx_start"}, int'(o_Tx_Start), 0);
    chk({tag, "_lock"}, int'(o_Write_Lock), 0);
    chk({tag, "_frame_ind"}, int'(o_Frame_Indicator), 1);
    chk({tag, "_busy"}, int'(o_Busy), 0);
  endtask

  initial begin
    int c1;
    bit ok;
    repeat (3) @(negedge Clk);
    chk_reset_vals("reset");
    i_Rst_n = 1'b1;
    repeat (3) @(negedge Clk);

    // 1: basic frame, lock and gap timing
    frame_starts = 0; push_frame();
    launch();
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge Clk);
      if (!o_Write_Lock) ok = 1;
    end
    chk("lock_fall_seen", int'(ok), 1);
    chk("busy_low_at_lock_fall", int'(i_Tx_Busy), 0);
    chk("starts_at_lock_fall", frame_starts, NSTART);
    chk("addr_wrapped", int'(o_Rd_Addr), 0);
    c1 = cyc; ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge Clk);
      if (o_Frame_Indicator) ok = 1;
    end
    chk("post_gap_len", cyc - c1, GAP);
    repeat (5) @(negedge Clk);

    // 2: long busy after the 2nd pixel start holds the address
    frame_starts = 0; long_mode = 1; push_frame();
    launch();
    wait_starts(HDR + 2, 1000);
    repeat (100) @(negedge Clk);
    chk("stall_addr", int'(o_Rd_Addr), 1);
    chk("stall_starts", frame_starts, HDR + 2);
    chk("stall_busy", int'(o_Busy), 1);
    wait_idle(2000);
    chk("stall_total_starts", frame_starts, NSTART);
    long_mode = 0;
    repeat (5) @(negedge Clk);

    // 3: VS edge mid-frame is ignored
    frame_starts = 0; idle_rises = 0; push_frame();
    launch();
    wait_starts(HDR + 1, 500);
    repeat (2) @(negedge Clk);
    i_VS = 1'b1;
    repeat (5) @(negedge Clk);
    i_VS = 1'b0;
    wait_idle(2000);
    repeat (60) @(negedge Clk);
    chk("midvs_starts", frame_starts, NSTART);
    chk("midvs_idle_returns", idle_rises, 1);
    chk("midvs_queue_empty", exp_q.size(), 0);

    // 4: reset during the 3rd pixel byte, then restart
    frame_starts = 0; push_frame();
    launch();
    wait_starts(HDR + 3, 1000);
    repeat (3) @(negedge Clk);
    i_Rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    exp_q.delete();
    @(negedge Clk);
    i_Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    frame_starts = 0; push_frame();
    launch();
    wait_idle(2000);
    chk("restart_starts", frame_starts, NSTART);

    // 6: VS glitch between clock edges
    repeat (5) @(negedge Clk);
    frame_starts = 0;
    @(negedge Clk);
    #1 i_VS = 1'b1;
    #2 i_VS = 1'b0;
    repeat (100) @(negedge Clk);
    chk("glitch_starts", frame_starts, 0);
    chk("glitch_idle", int'(o_Frame_Indicator), 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
